// File: rtl/biriscv_lsu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | biriscv_lsu_mem_responder: SRAM-backed in-order LSU data-memory target      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module biriscv_lsu_mem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int LATENCY      = 2,
  parameter int OUTSTANDING  = 2,
  parameter int MAINT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic        mem_writeback_i,
  input  logic        mem_invalidate_i,
  input  logic        mem_flush_i,
  input  logic [10:0] mem_req_tag_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic [31:0] mem_data_rd_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o
);

  localparam int c_aw = $clog2(DEPTH_WORDS);
  localparam int c_iw = $clog2(OUTSTANDING + 1);
  localparam int c_cw = $clog2(MAINT_CYCLES + 1);
  localparam int c_ns = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam logic [c_iw-1:0] c_outstanding = c_iw'(OUTSTANDING);
  localparam logic [c_cw-1:0] c_maint_last  = c_cw'(MAINT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_MAINT, ST_RESP} state_t;

  state_t            r_state;
  logic [c_iw-1:0]   r_inflight;
  logic [c_cw-1:0]   r_cnt;
  logic [10:0]       r_mtag;
  logic              r_ack;
  logic [31:0]       r_data;
  logic              r_err;
  logic [10:0]       r_tag;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic [1:0]        w_maint_cnt;
  logic              w_wr;
  logic              w_present;
  logic              w_illegal;
  logic [c_aw-1:0]   w_idx;
  logic              w_take;
  logic              w_maint_take;
  logic              w_new_vld;
  logic [31:0]       w_new_data;
  logic              w_wr_ok;
  logic              w_dec;
  logic              w_maint_done;
  logic              w_tail_vld;
  logic [31:0]       w_tail_data;
  logic              w_tail_err;
  logic [10:0]       w_tail_tag;

  assign w_maint_cnt = {1'b0, mem_writeback_i} + {1'b0, mem_invalidate_i} + {1'b0, mem_flush_i};
  assign w_wr        = |mem_wr_i;
  assign w_present   = mem_rd_i | w_wr | (w_maint_cnt != 2'd0);
  assign w_illegal   = (|mem_addr_i[1:0]) | (|mem_addr_i[31:c_aw+2]) | (mem_rd_i & w_wr) |
                       (w_maint_cnt > 2'd1) | ((w_maint_cnt != 2'd0) & (mem_rd_i | w_wr));
  assign w_idx       = mem_addr_i[c_aw+1:2];

  assign mem_accept_o = (r_state == ST_IDLE) && (r_inflight < c_outstanding) && !rst_i;

  assign w_take       = w_present & mem_accept_o;
  assign w_maint_take = w_take & ~w_illegal & (w_maint_cnt != 2'd0);
  assign w_new_vld    = w_take & ~w_maint_take;
  assign w_wr_ok      = w_take & ~w_illegal & w_wr;
  assign w_new_data   = (w_take & ~w_illegal & mem_rd_i) ? r_mem[w_idx] : 32'd0;
  // An ack retires its slot at the end of the cycle it is presented.
  assign w_dec        = r_ack & (r_state != ST_RESP);
  assign w_maint_done = (r_state == ST_MAINT) && (r_cnt == c_maint_last);

  generate
    if (LATENCY == 1) begin : g_lat_direct
      assign w_tail_vld  = w_new_vld;
      assign w_tail_data = w_new_data;
      assign w_tail_err  = w_illegal;
      assign w_tail_tag  = mem_req_tag_i;
    end else begin : g_lat_pipe
      logic [c_ns-1:0] r_pv;
      logic [c_ns-1:0] r_pe;
      logic [31:0]     r_pd [c_ns];
      logic [10:0]     r_pt [c_ns];

      always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
          r_pv <= '0;
          r_pe <= '0;
          for (int i = 0; i < c_ns; i++) begin
            r_pd[i] <= '0;
            r_pt[i] <= '0;
          end
        end else begin
          r_pv[0] <= w_new_vld;
          r_pe[0] <= w_illegal;
          r_pd[0] <= w_new_data;
          r_pt[0] <= mem_req_tag_i;
          for (int i = 1; i < c_ns; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
            r_pt[i] <= r_pt[i-1];
          end
        end
      end

      assign w_tail_vld  = r_pv[c_ns-1];
      assign w_tail_data = r_pd[c_ns-1];
      assign w_tail_err  = r_pe[c_ns-1];
      assign w_tail_tag  = r_pt[c_ns-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_i[b]) r_mem[w_idx][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_inflight <= '0;
      r_cnt      <= '0;
      r_mtag     <= '0;
      r_ack      <= 1'b0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_ack <= w_tail_vld | w_maint_done;
      if (w_tail_vld) begin
        r_data <= w_tail_data;
        r_err  <= w_tail_err;
        r_tag  <= w_tail_tag;
      end else if (w_maint_done) begin
        r_data <= '0;
        r_err  <= 1'b0;
        r_tag  <= r_mtag;
      end else begin
        r_data <= '0;
        r_err  <= 1'b0;
      end

      if (w_new_vld && !w_dec)      r_inflight <= r_inflight + c_iw'(1);
      else if (!w_new_vld && w_dec) r_inflight <= r_inflight - c_iw'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_maint_take) begin
            r_state <= ST_DRAIN;
            r_mtag  <= mem_req_tag_i;
          end
        end
        ST_DRAIN: begin
          if (r_inflight == '0) begin
            r_state <= ST_MAINT;
            r_cnt   <= '0;
          end
        end
        ST_MAINT: begin
          if (w_maint_done) r_state <= ST_RESP;
          else              r_cnt   <= r_cnt + c_cw'(1);
        end
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_ack_o      = r_ack;
  assign mem_data_rd_o  = r_data;
  assign mem_error_o    = r_err;
  assign mem_resp_tag_o = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_biriscv_lsu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_biriscv_lsu_mem_responder: scoreboard bench for the LSU memory responder |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_biriscv_lsu_mem_responder;

  localparam int DEPTH_WORDS  = 1024;
  localparam int LATENCY      = 2;
  localparam int OUTSTANDING  = 2;
  localparam int MAINT_CYCLES = 4;

  logic        clk;
  logic        rst_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_wr_i;
  logic        mem_rd_i;
  logic [3:0]  mem_wr_i;
  logic        mem_writeback_i;
  logic        mem_invalidate_i;
  logic        mem_flush_i;
  logic [10:0] mem_req_tag_i;
  logic        mem_accept_o;
  logic        mem_ack_o;
  logic [31:0] mem_data_rd_o;
  logic        mem_error_o;
  logic [10:0] mem_resp_tag_o;

  biriscv_lsu_mem_responder #(
    .DEPTH_WORDS  (DEPTH_WORDS),
    .LATENCY      (LATENCY),
    .OUTSTANDING  (OUTSTANDING),
    .MAINT_CYCLES (MAINT_CYCLES)
  ) dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .mem_addr_i       (mem_addr_i),
    .mem_data_wr_i    (mem_data_wr_i),
    .mem_rd_i         (mem_rd_i),
    .mem_wr_i         (mem_wr_i),
    .mem_writeback_i  (mem_writeback_i),
    .mem_invalidate_i (mem_invalidate_i),
    .mem_flush_i      (mem_flush_i),
    .mem_req_tag_i    (mem_req_tag_i),
    .mem_accept_o     (mem_accept_o),
    .mem_ack_o        (mem_ack_o),
    .mem_data_rd_o    (mem_data_rd_o),
    .mem_error_o      (mem_error_o),
    .mem_resp_tag_o   (mem_resp_tag_o)
  );

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    bit          maint;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          ack_cyc [2048];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          rw_out = 0;
  bit          acc_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Response scoreboard and accept-availability model
  always @(negedge clk) begin
    exp_t e;
    logic exp_acc;
    if (!rst_i) begin
      if (acc_chk) begin
        exp_acc = (rw_out < OUTSTANDING);
        checks++;
        if (mem_accept_o !== exp_acc) begin
          errors++;
          $display("FAIL accept_avail cyc %0d got %b exp %b", cyc, mem_accept_o, exp_acc);
        end
      end
      if (mem_ack_o === 1'b1) begin
        ack_cyc[mem_resp_tag_o] = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack cyc %0d got tag %0d exp none", cyc, mem_resp_tag_o);
        end else begin
          e = sb.pop_front();
          if (mem_resp_tag_o !== e.tag || mem_data_rd_o !== e.data ||
              mem_error_o !== e.err || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL resp got tag %0d data %h err %b cyc %0d exp tag %0d data %h err %b cyc %0d",
                     mem_resp_tag_o, mem_data_rd_o, mem_error_o, cyc, e.tag, e.data, e.err, e.cyc);
          end
          if (!e.maint) rw_out--;
        end
      end
    end
  end

  function automatic bit is_illegal(input logic [31:0] addr, input logic rd,
                                    input logic [3:0] wr, input logic [2:0] mnt);
    int n;
    n = int'(mnt[0]) + int'(mnt[1]) + int'(mnt[2]);
    return (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH_WORDS * 4)) || (rd && wr != 4'h0) ||
           (n > 1) || (n > 0 && (rd || wr != 4'h0));
  endfunction

  task automatic idle();
    mem_addr_i       = '0;
    mem_data_wr_i    = '0;
    mem_rd_i         = 1'b0;
    mem_wr_i         = '0;
    mem_writeback_i  = 1'b0;
    mem_invalidate_i = 1'b0;
    mem_flush_i      = 1'b0;
    mem_req_tag_i    = '0;
  endtask

  // Called at a negedge; holds the request until accepted, returns at a negedge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                       input logic [3:0] wr, input logic [2:0] mnt, input logic [10:0] tag);
    exp_t        e;
    bit          a;
    bit          done;
    bit          ill;
    int          k;
    logic [31:0] w;
    mem_addr_i       = addr;
    mem_data_wr_i    = wdata;
    mem_rd_i         = rd;
    mem_wr_i         = wr;
    mem_writeback_i  = mnt[2];
    mem_invalidate_i = mnt[1];
    mem_flush_i      = mnt[0];
    mem_req_tag_i    = tag;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      a = mem_accept_o;
      @(posedge clk);
      #1;
      if (a) begin
        ill     = is_illegal(addr, rd, wr, mnt);
        k       = int'(addr[31:2]);
        e.tag   = tag;
        e.err   = ill;
        e.maint = !ill && (mnt != 3'b000);
        e.cyc   = e.maint ? -1 : cyc + LATENCY - 1;
        e.data  = '0;
        if (!ill && rd) e.data = model.exists(k) ? model[k] : 32'd0;
        if (!ill && wr != 4'h0) begin
          w = model.exists(k) ? model[k] : 32'd0;
          for (int b = 0; b < 4; b++) if (wr[b]) w[8*b +: 8] = wdata[8*b +: 8];
          model[k] = w;
        end
        if (!e.maint) rw_out++;
        sb.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag %0d got no accept exp accept", tag);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    checks++; if (mem_ack_o !== 1'b0)      begin errors++; $display("FAIL rst_ack got %b exp 0", mem_ack_o); end
    checks++; if (mem_data_rd_o !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", mem_data_rd_o); end
    checks++; if (mem_error_o !== 1'b0)    begin errors++; $display("FAIL rst_err got %b exp 0", mem_error_o); end
    checks++; if (mem_resp_tag_o !== 11'd0) begin errors++; $display("FAIL rst_tag got %0d exp 0", mem_resp_tag_o); end
    checks++; if (mem_accept_o !== 1'b0)   begin errors++; $display("FAIL rst_accept got %b exp 0", mem_accept_o); end
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_accept_o !== 1'b1)   begin errors++; $display("FAIL post_rst_accept got %b exp 1", mem_accept_o); end
  endtask

  task automatic test_write_read();
    acc_chk = 1;
    issue(32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 3'b000, 11'd5);
    issue(32'h10, 32'h0,        1'b1, 4'h0, 3'b000, 11'd6);
    idle();
    wait_drain();
    checks++;
    if (ack_cyc[6] - ack_cyc[5] != 1) begin
      errors++;
      $display("FAIL wr_rd_spacing got %0d exp 1", ack_cyc[6] - ack_cyc[5]);
    end
  endtask

  task automatic test_byte_write();
    issue(32'h10, 32'h000000AA, 1'b0, 4'h1, 3'b000, 11'd7);
    issue(32'h10, 32'h0,        1'b1, 4'h0, 3'b000, 11'd8);
    issue(32'h20, 32'h11223344, 1'b0, 4'hF, 3'b000, 11'd40);
    issue(32'h20, 32'hAABBCCDD, 1'b0, 4'h6, 3'b000, 11'd41);
    issue(32'h20, 32'h0,        1'b1, 4'h0, 3'b000, 11'd42);
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      issue((i % 2 == 0) ? 32'h10 : 32'h20, 32'h0, 1'b1, 4'h0, 3'b000, 11'(10 + i));
    idle();
    wait_drain();
    checks++;
    if (!(ack_cyc[10] < ack_cyc[11] && ack_cyc[11] < ack_cyc[12] && ack_cyc[12] < ack_cyc[13])) begin
      errors++;
      $display("FAIL b2b_order got %0d %0d %0d %0d exp increasing",
               ack_cyc[10], ack_cyc[11], ack_cyc[12], ack_cyc[13]);
    end
  endtask

  task automatic test_illegal();
    issue(32'h2,                  32'h0,        1'b1, 4'h0, 3'b000, 11'd20);
    issue(32'(DEPTH_WORDS * 4),   32'h0,        1'b1, 4'h0, 3'b000, 11'd21);
    issue(32'(DEPTH_WORDS * 4),   32'h55555555, 1'b0, 4'hF, 3'b000, 11'd22);
    issue(32'h10,                 32'h12345678, 1'b1, 4'hF, 3'b000, 11'd23);
    issue(32'h10,                 32'h0,        1'b0, 4'h0, 3'b101, 11'd24);
    issue(32'h12,                 32'h99999999, 1'b0, 4'hF, 3'b000, 11'd25);
    issue(32'h10,                 32'h0,        1'b1, 4'h0, 3'b000, 11'd26);
    idle();
    wait_drain();
    acc_chk = 0;
  endtask

  task automatic test_flush();
    bit seen;
    int viol;
    int gap;
    issue(32'h30, 32'h12345678, 1'b0, 4'hF, 3'b000, 11'd1);
    issue(32'h30, 32'h0,        1'b0, 4'h0, 3'b001, 11'd2);
    idle();
    seen = 0;
    viol = 0;
    gap  = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (mem_ack_o === 1'b1 && mem_resp_tag_o === 11'd2) begin
        seen = 1;
        gap  = cyc - ack_cyc[1];
      end else begin
        if (mem_accept_o !== 1'b0) viol++;
        @(negedge clk);
      end
    end
    checks++; if (!seen)    begin errors++; $display("FAIL flush_ack got none exp tag 2"); end
    checks++; if (viol != 0) begin errors++; $display("FAIL flush_accept_low got %0d high cycles exp 0", viol); end
    checks++;
    if (gap < MAINT_CYCLES || gap > MAINT_CYCLES + 3) begin
      errors++;
      $display("FAIL flush_gap got %0d exp %0d..%0d", gap, MAINT_CYCLES, MAINT_CYCLES + 3);
    end
    @(negedge clk);
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL flush_accept_back got %b exp 1", mem_accept_o); end
    wait_drain();
    acc_chk = 1;
    issue(32'h30, 32'h0, 1'b1, 4'h0, 3'b000, 11'd3);
    idle();
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    int acks;
    issue(32'h10, 32'h0, 1'b1, 4'h0, 3'b000, 11'd30);
    issue(32'h20, 32'h0, 1'b1, 4'h0, 3'b000, 11'd31);
    idle();
    #2;
    rst_i   = 1'b1;
    acc_chk = 0;
    sb.delete();
    rw_out  = 0;
    @(negedge clk);
    checks++; if (mem_ack_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %b exp 0", mem_ack_o); end
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_accept_o !== 1'b1) begin errors++; $display("FAIL rst_rel_accept got %b exp 1", mem_accept_o); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_ack_o !== 1'b0) acks++;
      @(negedge clk);
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL rst_stale_acks got %0d exp 0", acks); end
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_write();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/biriscv_lsu_mem_responder.md
Name: biriscv_lsu_mem_responder

Overview:
- Memory-side responder for the biriscv LSU data-memory interface. It is the target that receives LSU read, write, writeback, flush and invalidate requests and returns accept, ack, read data, error and response tag.
- Backed by an internal word-addressed SRAM model. Used as the dcache/TCM stand-in in LSU subsystem benches and small FPGA builds.
- Responses are in-order, with fixed pipeline latency and a bounded number of outstanding requests.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of backing storage (power of 2).
- LATENCY, 2, cycles from the accepting edge to ack for read/write (legal range 1..4).
- OUTSTANDING, 2, maximum accepted-but-unacked read/write requests (1..4).
- MAINT_CYCLES, 4, busy cycles spent on a maintenance op (>=1).

Ports:
- clk  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mem_addr_i  in  32  byte address of request
- mem_data_wr_i  in  32  write data
- mem_rd_i  in  1  read request
- mem_wr_i  in  4  write byte strobes; nonzero means write request
- mem_writeback_i  in  1  writeback maintenance request
- mem_invalidate_i  in  1  invalidate maintenance request
- mem_flush_i  in  1  flush maintenance request
- mem_req_tag_i  in  11  request tag
- mem_accept_o  out  1  request accepted this cycle
- mem_ack_o  out  1  response valid (single cycle)
- mem_data_rd_o  out  32  read data, valid with ack
- mem_error_o  out  1  response is an error, valid with ack
- mem_resp_tag_o  out  11  tag of the responded request

Behaviour:
- Request present = mem_rd_i | (mem_wr_i!=0) | mem_writeback_i | mem_invalidate_i | mem_flush_i. A request is taken on a rising edge where present & mem_accept_o.
- mem_accept_o is a function of registered state only; it must not depend combinationally on request inputs. It is high iff state==IDLE, inflight<OUTSTANDING and rst_i low.
- Reset values: mem_ack_o=0, mem_data_rd_o=0, mem_error_o=0, mem_resp_tag_o=0, state IDLE, inflight=0, pipeline cleared. SRAM contents are not reset.
- Reset mid-operation discards all in-flight responses. No ack follows reset release.
- Illegal request: any of the following, accepted normally, no storage effect, acked through the read/write pipeline with mem_error_o=1 and data 0:
  - addr[1:0]!=0
  - addr>=DEPTH_WORDS*4
  - rd together with wr!=0
  - more than one maintenance bit set
  - a maintenance bit together with rd or wr
- Write: storage is updated at the accepting edge, per byte lane enabled by mem_wr_i[n]. Ack after LATENCY cycles with data 0 and error 0.
- Read: data is sampled at the accepting edge, so a read accepted one cycle after a write to the same word returns the new bytes. Ack after LATENCY cycles.
- Latency: request accepted at edge N gives mem_ack_o high in the cycle following edge N+LATENCY-1. Back-to-back accepts give back-to-back acks in order, each with its own tag.
- inflight counter:
  - +1 on accept of a read, write or illegal request.
  - −1 on the corresponding ack.
  - Simultaneous accept and ack leave it unchanged.
  - It never exceeds OUTSTANDING and never underflows.
- Maintenance FSM (one legal maintenance bit):
  - IDLE → DRAIN on accept, latching the tag.
  - DRAIN → MAINT when inflight==0 (immediately if already 0).
  - MAINT counts MAINT_CYCLES cycles, then → RESP.
  - RESP drives ack for 1 cycle with data 0, error 0 and the latched tag, then → IDLE.
  - mem_accept_o is 0 in DRAIN, MAINT and RESP.
  - Maintenance ops have no effect on storage.
- A maintenance ack never coincides with a read/write ack; DRAIN guarantees ordering.

Test Plan:
- Reset, then write 0xDEADBEEF strobe 0xF to 0x10, tag 5; read 0x10, tag 6 next cycle → acks at accept+2 and accept+3; read ack data 0xDEADBEEF, tags 5 then 6, error 0.
- Byte write 0x000000AA strobe 0x1 to 0x10, then read → data 0xDEADBEAA.
- Four back-to-back reads with OUTSTANDING=2, LATENCY=2 → accept drops after the second accept, reasserts as acks return; all 4 acked in tag order; inflight never exceeds 2.
- Read 0x2 (misaligned) and read DEPTH_WORDS*4 → both acked with mem_error_o=1, data 0; storage unchanged.
- Write tag 1 followed by flush tag 2 → accept low until flush ack; flush ack arrives after write ack plus MAINT_CYCLES cycles, tag 2, then accept returns to 1.
- Assert rst_i while two reads are in flight → no acks after release; accept=1 on the first cycle after release.
